// File: rtl/mima_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, grant ID and
// default widths. Imported by mem_arbiter and arb_pick.
package mima_pkg;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic       {GNT_IF, GNT_D}                gnt_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker between the fetch and data ports.
// Ports: if_req, d_req (requests), last_gnt (previous winner) -> gnt (winner).
// Build option MEM_ARB_RR_EN: when defined, a tie goes to the side that did
// not win last time; when undefined, data always beats fetch on a tie.
// The output is a don't-care when neither side requests.
module arb_pick
    import mima_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  gnt_t last_gnt,
    output gnt_t gnt
);

    always_comb begin
        gnt = GNT_IF;
        if (d_req && !if_req) begin
            gnt = GNT_D;
        end else if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
            gnt = (last_gnt == GNT_IF) ? GNT_D : GNT_IF;
`else
            // Data belongs to the older instruction, so it goes first.
            gnt = GNT_D;
`endif
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last_gnt;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the sccpu
// instruction-fetch and data ports. Grants one request at a time, registers
// it onto the memory port, and returns read data with a one-cycle ack.
// Ports:
//   clk, rst           clock / async active-low reset
//   if_req/addr        fetch request in; if_rdata/if_ack response out
//   d_req/we/be/addr/wdata  data request in; d_rdata/d_ack response out
//   err                timeout flag, valid with either ack
//   mem_req/we/be/addr/wdata  memory request out; mem_rdata/mem_ready in
//   stall              CPU stall, combinational from req/ack pins
// Build option MEM_ARB_RR_EN selects round-robin tie-break (see arb_pick).
module mem_arbiter
    import mima_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_ack,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic [DW-1:0]   d_rdata,
    output logic            d_ack,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic            stall
);

    localparam int BW = DW / 8;
    // Counter only has to reach TIMEOUT_CYC-1.
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t    state_q, state_d;
    gnt_t          gnt_q, gnt_d;
    gnt_t          last_q, last_d;
    gnt_t          pick;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          timeout_hit;

    arb_pick u_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_gnt (last_q),
        .gnt      (pick)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    state_d   = ARB_BUSY;
                    gnt_d     = pick;
                    last_d    = pick;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                    if (pick == GNT_D) begin
                        mem_we_d    = d_we;
                        mem_be_d    = d_be;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end
            ARB_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ready || timeout_hit) begin
                    state_d   = ARB_RESP;
                    mem_req_d = 1'b0;
                    // Writes and timeouts return zero data; err marks the timeout.
                    rdata_d   = (mem_ready && !mem_we_q) ? mem_rdata : '0;
                    err_d     = !mem_ready;
                    if (gnt_q == GNT_D) d_ack_d  = 1'b1;
                    else                if_ack_d = 1'b1;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= GNT_IF;
            last_q      <= GNT_IF;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (TIMEOUT_CYC=8). Stimulus pushes the
// expected memory request and CPU response; a memory responder checks the
// request fields every BUSY cycle, and an ack monitor pops and compares.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, err, mem_req, mem_we, mem_ready, stall;
    logic [3:0]  mem_be;

    logic        mem_ready_auto, mem_ready_man;
    bit          mem_auto = 1'b1;

    always #5 clk = ~clk;

    assign mem_ready = mem_auto ? mem_ready_auto : mem_ready_man;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall)
    );

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          full;   // check be/wdata too (data port only)
        int          wt;     // mem_ready on this BUSY cycle; 0 = never
    } mexp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    hi_cycles;
    bit    tb_last_d = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Ack monitor
    initial begin
        rexp_t r;
        forever begin
            @(negedge clk);
            if (if_ack || d_ack) begin
                chk("dual_ack", 32'(if_ack & d_ack), 32'd0);
                if (rq.size() == 0) begin
                    chk("ack_pending", 32'(rq.size()), 32'd1);
                end else begin
                    r = rq.pop_front();
                    chk("ack_port", 32'(d_ack), 32'(r.is_d));
                    chk("ack_rdata", r.is_d ? d_rdata : if_rdata, r.rdata);
                    chk("ack_err", 32'(err), 32'(r.err));
                end
            end
        end
    end

    // Memory responder
    initial begin
        int    k;
        bit    has_cur;
        mexp_t cur;
        k = 0; has_cur = 1'b0;
        mem_ready_auto = 1'b0;
        mem_rdata = 32'h0BAD0BAD;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                k++;
                if (k == 1) begin
                    if (mq.size() == 0) chk("mem_req_expected", 32'(mq.size()), 32'd1);
                    else begin cur = mq.pop_front(); has_cur = 1'b1; end
                end
                if (has_cur) begin
                    chk("mem_we", 32'(mem_we), 32'(cur.we));
                    chk("mem_addr", mem_addr, cur.addr);
                    if (cur.full) begin
                        chk("mem_be", 32'(mem_be), 32'(cur.be));
                        chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                    mem_ready_auto = (cur.wt != 0) && (k == cur.wt);
                    mem_rdata = mem_ready_auto ? cur.rdata : 32'h0BAD0BAD;
                end
            end else begin
                if (k > 0) hi_cycles = k;
                k = 0;
                has_cur = 1'b0;
                mem_ready_auto = 1'b0;
            end
        end
    end

    task automatic xact(input string nm, input bit is_d, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int wt, input bit perturb);
        mexp_t m;
        rexp_t r;
        int    cyc;
        bit    got;
        m.we = is_d ? we : 1'b0; m.be = be; m.addr = addr; m.wdata = wdata;
        m.rdata = rd; m.full = is_d; m.wt = wt;
        r.is_d = is_d;
        r.rdata = (wt == 0 || (is_d && we)) ? 32'd0 : rd;
        r.err = (wt == 0);
        mq.push_back(m);
        rq.push_back(r);
        hi_cycles = -1;
        if (is_d) begin
            d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (perturb && cyc == 2) begin
                d_addr = ~addr; d_wdata = ~wdata; d_be = ~be; d_we = ~we;
            end
            got = is_d ? d_ack : if_ack;
        end
        chk({nm, "_ack_seen"}, 32'(got), 32'd1);
        chk({nm, "_latency"}, 32'(cyc), 32'((wt == 0) ? 9 : wt + 1));
        chk({nm, "_stall_in_ack"}, 32'(stall), 32'd0);
        if_req = 1'b0; d_req = 1'b0;
        d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
        @(negedge clk);
        chk({nm, "_ack_pulse"}, 32'(is_d ? d_ack : if_ack), 32'd0);
        chk({nm, "_mem_req_cycles"}, 32'(hi_cycles), 32'((wt == 0) ? 8 : wt));
        tb_last_d = is_d;
    endtask

    task automatic tie(input string nm, input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ird, input logic [31:0] drd);
        bit    d_first;
        mexp_t md, mi;
        rexp_t rd_, ri;
        int    n_ack, cyc;
`ifdef MEM_ARB_RR_EN
        d_first = !tb_last_d;
`else
        d_first = 1'b1;
`endif
        md.we = 1'b0; md.be = 4'hF; md.addr = da; md.wdata = 32'h0; md.rdata = drd; md.full = 1'b1; md.wt = 1;
        mi.we = 1'b0; mi.be = 4'hF; mi.addr = ia; mi.wdata = 32'h0; mi.rdata = ird; mi.full = 1'b0; mi.wt = 1;
        rd_.is_d = 1'b1; rd_.rdata = drd; rd_.err = 1'b0;
        ri.is_d = 1'b0;  ri.rdata = ird;  ri.err = 1'b0;
        if (d_first) begin
            mq.push_back(md); mq.push_back(mi); rq.push_back(rd_); rq.push_back(ri);
        end else begin
            mq.push_back(mi); mq.push_back(md); rq.push_back(ri); rq.push_back(rd_);
        end
        d_we = 1'b0; d_be = 4'hF; d_addr = da; d_wdata = 32'h0; if_addr = ia;
        d_req = 1'b1; if_req = 1'b1;
        n_ack = 0; cyc = 0;
        while (n_ack < 2 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (d_ack) begin
                chk({nm, "_stall_d_ack"}, 32'(stall), 32'(if_req));
                d_req = 1'b0; n_ack++;
            end
            if (if_ack) begin
                chk({nm, "_stall_if_ack"}, 32'(stall), 32'(d_req));
                if_req = 1'b0; n_ack++;
            end
        end
        chk({nm, "_acks"}, 32'(n_ack), 32'd2);
        if_req = 1'b0; d_req = 1'b0;
        tb_last_d = !d_first;
        @(negedge clk);
    endtask

    initial begin
        // 1: reset with both requests high
        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_ready_man = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 2: fetch, memory ready on the second BUSY cycle
        xact("fetch", 1'b0, 1'b0, 4'hF, 32'h40, 32'h0, 32'hDEADBEEF, 2, 1'b0);
        // 3: tie after a fetch grant, then a data grant, then tie again
        tie("tieA", 32'h44, 32'h300, 32'hA1A1A1A1, 32'hB2B2B2B2);
        xact("dread", 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h11112222, 1, 1'b0);
        tie("tieB", 32'h48, 32'h304, 32'hC3C3C3C3, 32'hD4D4D4D4);
        // 4: write with inputs disturbed while BUSY
        xact("write", 1'b1, 1'b1, 4'b0011, 32'h100, 32'h1234ABCD, 32'hFFFFFFFF, 3, 1'b1);
        // 5: timeout, then a normal read clears err
        xact("timeout", 1'b0, 1'b0, 4'hF, 32'h60, 32'h0, 32'h55555555, 0, 1'b0);
        xact("after_to", 1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 32'h76543210, 1, 1'b0);

        // 6: reset during BUSY, late mem_ready after release
        begin
            mexp_t m;
            m.we = 1'b0; m.be = 4'hF; m.addr = 32'h80; m.wdata = 32'h0;
            m.rdata = 32'h0; m.full = 1'b0; m.wt = 0;
            mq.push_back(m);
            if_addr = 32'h80; if_req = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst6_busy", 32'(mem_req), 32'd1);
            #2 rst = 1'b0;
            #1 chk("rst6_mem_req_async", 32'(mem_req), 32'd0);
            if_req = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            mem_auto = 1'b0; mem_ready_man = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("rst6_no_ack", 32'(if_ack | d_ack), 32'd0);
                chk("rst6_mem_req", 32'(mem_req), 32'd0);
                if (i == 1) mem_ready_man = 1'b0;
            end
            mem_auto = 1'b1;
        end

        // recovery after reset
        xact("recover", 1'b0, 1'b0, 4'hF, 32'h84, 32'h0, 32'h0F0F0F0F, 1, 1'b0);

        chk("mq_drained", 32'(mq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
